ei_axi4_slave_wr_ctrl: RTL and testbench
========================================

// Module: ei_axi4_slave_wr_ctrl
// PURPOSE
//  AXI4 slave write-path controller: the RTL DUT driven by the VIP master agent inside the top bench.
//  Accepts AW and W bursts, generates per-beat word addresses and drives a memory write port.
//  Returns one B response per burst. One burst in flight; AW and W are serialised.
// PARAMETERS
//  ADDR_WIDTH  32    awaddr width (bits)
//  DATA_WIDTH  32    wdata width (bits); power of 2, >=8; beats are always full-width
//  ID_WIDTH    4     awid/bid width
//  MEM_DEPTH   1024  memory depth in DATA_WIDTH words; MAW = $clog2(MEM_DEPTH)
// PORTS
//  aclk       in   1              clock, all logic on rising edge
//  aresetn    in   1              asynchronous active-low reset
//  awid       in   ID_WIDTH       write burst ID
//  awaddr     in   ADDR_WIDTH     burst start byte address
//  awlen      in   8              beats-1
//  awburst    in   2              FIXED=0, INCR=1, WRAP=2 (3 is reserved -> SLVERR, treated as INCR)
//  awvalid    in   1              AW valid
//  awready    out  1              AW ready
//  wdata      in   DATA_WIDTH     write data
//  wstrb      in   DATA_WIDTH/8   byte strobes
//  wlast      in   1              last-beat marker from master
//  wvalid     in   1              W valid
//  wready     out  1              W ready
//  bid        out  ID_WIDTH       response ID (latched awid)
//  bresp      out  2              OKAY=0, SLVERR=2, DECERR=3
//  bvalid     out  1              B valid
//  bready     in   1              B ready
//  mem_we     out  1              memory write enable, one cycle per accepted in-range beat
//  mem_addr   out  MAW            word address of the current beat
//  mem_wdata  out  DATA_WIDTH     = wdata
//  mem_wstrb  out  DATA_WIDTH/8   = wstrb
// BEHAVIOUR
//  - FSM: RST_WAIT -> IDLE -> DATA -> RESP -> IDLE. Reset forces RST_WAIT. RST_WAIT lasts exactly 1 clock.
//  - Outputs during and after reset: awready=0, wready=0, bvalid=0, bid=0, bresp=0, mem_we=0, mem_addr=0.
//  - Ready/valid decode from state: awready=(IDLE); wready=(DATA); bvalid=(RESP).
//  - IDLE: on awvalid&&awready, latch id, len, burst and word address (awaddr>>log2(DATA_WIDTH/8); low bits dropped). Clear beat count and error flags. Next state is DATA, so wready rises the cycle after the AW handshake.
//  - DATA: mem_we=wvalid&&wready&&(word addr<MEM_DEPTH); this is combinational, in the same cycle as the beat. On each beat, increment the beat counter and advance the address:
//    - FIXED: hold.
//    - INCR: +1, wrapping modulo 2^(ADDR_WIDTH-log2(DATA_WIDTH/8)).
//    - WRAP: base=addr&~len; next=base|((addr+1)&len).
//  - Beat count, not wlast, ends the burst. The beat where count==awlen moves the FSM to RESP, so bvalid is asserted the next cycle.
//  - Error rules:
//    - wlast!=(count==awlen) on any beat sets SLVERR.
//    - WRAP with awlen not in {1,3,7,15} sets SLVERR; addresses still advance with the WRAP formula.
//    - Reserved burst type sets SLVERR.
//    - Any out-of-range beat sets DECERR and is not written.
//    - Priority: DECERR > SLVERR > OKAY.
//  - RESP: bvalid/bid/bresp stay stable until bready. The next state is IDLE, so the earliest following AW handshake is 1 cycle after the B handshake.
//  - Reset mid-burst: the burst is abandoned and no B is issued. mem_we drops asynchronously with aresetn.
// STRUCTURE
//  - Shared package ei_axi4_pkg: burst_e {FIXED,INCR,WRAP}, resp_e {OKAY,EXOKAY,SLVERR,DECERR}, wr_state_e.
//  - One sub-module, ei_axi4_burst_addr_gen: combinational next-address from (addr,len,burst), with the WRAP length check.
// TESTING
//  1. INCR awlen=3, awaddr=0x10, wdata 1..4, bready=1 -> mem_addr 4,5,6,7. bvalid 1 cycle after beat 4, bresp=0, bid=awid.
//  2. WRAP awlen=3, awaddr=0x18 -> mem_addr 6,7,4,5, bresp=0. WRAP awlen=2 -> bresp=2.
//  3. FIXED awlen=2, awaddr=0x20 -> 3 writes to mem_addr 8, last data wins, bresp=0.
//  4. wlast on beat 2 of awlen=3 -> all 4 beats accepted and written, bresp=2, exactly 1 B.
//  5. INCR awlen=1, awaddr=0xFFC (MEM_DEPTH=1024) -> word 1023 written, word 1024 suppressed, bresp=3. bready low 5 cycles -> bvalid and bresp held, awready=0.
//  6. aresetn low after beat 2 of awlen=7 -> wready and mem_we 0 at once, no bvalid. awready=1 on 2nd edge after release.

Source files
------------

// File: rtl/ei_axi4_pkg.sv
// Shared AXI4 types for the slave write path: burst and response encodings and controller states.
package ei_axi4_pkg;

  typedef enum logic [1:0] {
    BurstFixed = 2'd0,
    BurstIncr  = 2'd1,
    BurstWrap  = 2'd2
  } burst_e;

  typedef enum logic [1:0] {
    RespOkay   = 2'd0,
    RespExokay = 2'd1,
    RespSlverr = 2'd2,
    RespDecerr = 2'd3
  } resp_e;

  typedef enum logic [1:0] {
    StRstWait = 2'd0,
    StIdle    = 2'd1,
    StData    = 2'd2,
    StResp    = 2'd3
  } wr_state_e;

  // Wrapping bursts must cover 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/ei_axi4_burst_addr_gen.sv
// Combinational next-word-address for an AXI4 burst, flagging illegal wrap lengths and
// the reserved burst type.
module ei_axi4_burst_addr_gen
  import ei_axi4_pkg::*;
#(
  parameter int unsigned WAW = 30
) (
  input  logic [WAW-1:0] i_addr,
  input  logic [7:0]     i_len,
  input  logic [1:0]     i_burst,
  output logic [WAW-1:0] o_addr_next,
  output logic           o_err
);

  logic [WAW-1:0] w_len_ext;
  logic [WAW-1:0] w_incr;

  assign w_len_ext = WAW'(i_len);
  assign w_incr    = i_addr + WAW'(1);

  always_comb begin
    o_addr_next = w_incr;
    o_err       = 1'b0;
    case (i_burst)
      BurstFixed: o_addr_next = i_addr;
      BurstIncr:  o_addr_next = w_incr;
      BurstWrap: begin
        // Illegal lengths still follow the wrap formula; only the response is flagged.
        o_addr_next = (i_addr & ~w_len_ext) | (w_incr & w_len_ext);
        o_err       = !wrap_len_ok(i_len);
      end
      default: begin
        o_addr_next = w_incr;
        o_err       = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/ei_axi4_slave_wr_ctrl.sv
// AXI4 slave write controller: one burst in flight, AW then W then B, driving a word-wide
// memory write port.
module ei_axi4_slave_wr_ctrl
  import ei_axi4_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned MEM_DEPTH  = 1024
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic [ID_WIDTH-1:0]          awid,
  input  logic [ADDR_WIDTH-1:0]        awaddr,
  input  logic [7:0]                   awlen,
  input  logic [1:0]                   awburst,
  input  logic                         awvalid,
  output logic                         awready,
  input  logic [DATA_WIDTH-1:0]        wdata,
  input  logic [DATA_WIDTH/8-1:0]      wstrb,
  input  logic                         wlast,
  input  logic                         wvalid,
  output logic                         wready,
  output logic [ID_WIDTH-1:0]          bid,
  output logic [1:0]                   bresp,
  output logic                         bvalid,
  input  logic                         bready,
  output logic                         mem_we,
  output logic [$clog2(MEM_DEPTH)-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]        mem_wdata,
  output logic [DATA_WIDTH/8-1:0]      mem_wstrb
);

  localparam int unsigned MAW   = $clog2(MEM_DEPTH);
  localparam int unsigned OFS_W = $clog2(DATA_WIDTH / 8);
  localparam int unsigned WAW   = ADDR_WIDTH - OFS_W;

  wr_state_e         r_state;
  wr_state_e         w_state_next;
  logic [ID_WIDTH-1:0] r_id;
  logic [7:0]        r_len;
  logic [7:0]        r_cnt;
  logic [1:0]        r_burst;
  logic [WAW-1:0]    r_addr;
  logic              r_slverr;
  logic              r_decerr;

  logic [WAW-1:0]    w_aw_word;
  logic [WAW-1:0]    w_addr_next;
  logic              w_burst_err;
  logic              w_in_range;
  logic              w_last_beat;
  logic              w_aw_hs;
  logic              w_beat;
  resp_e             w_resp;

  ei_axi4_burst_addr_gen #(
    .WAW(WAW)
  ) u_addr_gen (
    .i_addr      (r_addr),
    .i_len       (r_len),
    .i_burst     (r_burst),
    .o_addr_next (w_addr_next),
    .o_err       (w_burst_err)
  );

  assign w_aw_word   = WAW'(awaddr >> OFS_W);
  assign w_in_range  = r_addr < WAW'(MEM_DEPTH);
  assign w_last_beat = r_cnt == r_len;
  assign w_aw_hs     = awvalid && awready;
  assign w_beat      = wvalid && wready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= StRstWait;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StRstWait: w_state_next = StIdle;
      StIdle:    if (awvalid) w_state_next = StData;
      // The beat count closes the burst; wlast only feeds the error check.
      StData:    if (wvalid && w_last_beat) w_state_next = StResp;
      StResp:    if (bready) w_state_next = StIdle;
      default:   w_state_next = StRstWait;
    endcase
  end

  always_comb begin
    awready = r_state == StIdle;
    wready  = r_state == StData;
    bvalid  = r_state == StResp;
    mem_we  = (r_state == StData) && wvalid && w_in_range;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_id     <= '0;
      r_len    <= '0;
      r_cnt    <= '0;
      r_burst  <= '0;
      r_addr   <= '0;
      r_slverr <= 1'b0;
      r_decerr <= 1'b0;
    end else if (w_aw_hs) begin
      r_id     <= awid;
      r_len    <= awlen;
      r_cnt    <= '0;
      r_burst  <= awburst;
      r_addr   <= w_aw_word;
      r_slverr <= 1'b0;
      r_decerr <= 1'b0;
    end else if (w_beat) begin
      r_cnt  <= r_cnt + 8'd1;
      r_addr <= w_addr_next;
      if ((wlast != w_last_beat) || w_burst_err) begin
        r_slverr <= 1'b1;
      end
      if (!w_in_range) begin
        r_decerr <= 1'b1;
      end
    end
  end

  always_comb begin
    if (r_decerr) begin
      w_resp = RespDecerr;
    end else if (r_slverr) begin
      w_resp = RespSlverr;
    end else begin
      w_resp = RespOkay;
    end
  end

  assign bid       = r_id;
  assign bresp     = w_resp;
  assign mem_addr  = r_addr[MAW-1:0];
  assign mem_wdata = wdata;
  assign mem_wstrb = wstrb;

endmodule

// File: tb/tb_ei_axi4_slave_wr_ctrl.sv
// Directed bench for the AXI4 slave write controller with a queue-based scoreboard.
module tb_ei_axi4_slave_wr_ctrl;
  import ei_axi4_pkg::*;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [3:0]  awid = '0;
  logic [31:0] awaddr = '0;
  logic [7:0]  awlen = '0;
  logic [1:0]  awburst = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wlast = 1'b0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b1;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_t;

  typedef struct {
    logic [3:0] id;
    logic [1:0] resp;
  } b_t;

  wr_t exp_wr[$];
  b_t  exp_b[$];

  ei_axi4_slave_wr_ctrl #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .ID_WIDTH   (4),
    .MEM_DEPTH  (1024)
  ) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .awid      (awid),
    .awaddr    (awaddr),
    .awlen     (awlen),
    .awburst   (awburst),
    .awvalid   (awvalid),
    .awready   (awready),
    .wdata     (wdata),
    .wstrb     (wstrb),
    .wlast     (wlast),
    .wvalid    (wvalid),
    .wready    (wready),
    .bid       (bid),
    .bresp     (bresp),
    .bvalid    (bvalid),
    .bready    (bready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write-port strobe and B handshake is matched against the scoreboard.
  initial begin
    wr_t ew;
    b_t  eb;
    forever begin
      @(negedge aclk);
      if (mem_we) begin
        if (exp_wr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %0h data %0h, none expected", mem_addr,
                   mem_wdata);
        end else begin
          ew = exp_wr.pop_front();
          check("mem_addr", mem_addr, ew.addr);
          check("mem_wdata", mem_wdata, ew.data);
          check("mem_wstrb", mem_wstrb, ew.strb);
        end
      end
      if (bvalid && bready) begin
        if (exp_b.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_b: got bid %0h bresp %0h, none expected", bid, bresp);
        end else begin
          eb = exp_b.pop_front();
          check("bid", bid, eb.id);
          check("bresp", bresp, eb.resp);
        end
      end
    end
  end

  task automatic aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                    input logic [1:0] burst, input logic [1:0] exp_resp, input bit push_b);
    int n;
    if (push_b) exp_b.push_back(b_t'{id, exp_resp});
    awid = id; awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
    n = 0;
    forever begin
      @(negedge aclk);
      if (awready) break;
      n++;
      if (n > 100) begin
        checks++; errors++;
        $display("FAIL aw_timeout: awready stayed 0, required 1");
        break;
      end
    end
    @(posedge aclk);
    #1 awvalid = 1'b0;
    @(negedge aclk);
    check("wready_after_aw", wready, 1'b1);
    check("awready_in_data", awready, 1'b0);
    @(posedge aclk);
    #1;
  endtask

  task automatic beat(input logic [31:0] data, input logic [3:0] strb, input logic last,
                      input bit exp_we, input logic [9:0] exp_addr);
    int n;
    if (exp_we) exp_wr.push_back(wr_t'{exp_addr, data, strb});
    wdata = data; wstrb = strb; wlast = last; wvalid = 1'b1;
    n = 0;
    forever begin
      @(negedge aclk);
      if (wready) break;
      n++;
      if (n > 100) begin
        checks++; errors++;
        $display("FAIL w_timeout: wready stayed 0, required 1");
        break;
      end
    end
    @(posedge aclk);
    #1 wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic finish_burst();
    @(negedge aclk);
    check("bvalid_after_last", bvalid, 1'b1);
    @(posedge aclk);
    #1;
    @(negedge aclk);
    check("bvalid_after_b_hs", bvalid, 1'b0);
    @(posedge aclk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #2;
    check("rst_awready", awready, 1'b0);
    check("rst_wready", wready, 1'b0);
    check("rst_bvalid", bvalid, 1'b0);
    check("rst_bid", bid, 4'h0);
    check("rst_bresp", bresp, 2'h0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 10'h0);
    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b1;
    @(posedge aclk);
    @(posedge aclk);
    #1 check("awready_after_reset", awready, 1'b1);

    // INCR 4 beats from byte 0x10 -> words 4..7
    aw(4'h3, 32'h10, 8'd3, BurstIncr, RespOkay, 1'b1);
    beat(32'd1, 4'hF, 1'b0, 1'b1, 10'd4);
    beat(32'd2, 4'h3, 1'b0, 1'b1, 10'd5);
    beat(32'd3, 4'hC, 1'b0, 1'b1, 10'd6);
    beat(32'd4, 4'hF, 1'b1, 1'b1, 10'd7);
    finish_burst();

    // WRAP 4 beats from word 6 wraps inside 4..7
    aw(4'h5, 32'h18, 8'd3, BurstWrap, RespOkay, 1'b1);
    beat(32'hA0, 4'hF, 1'b0, 1'b1, 10'd6);
    beat(32'hA1, 4'hF, 1'b0, 1'b1, 10'd7);
    beat(32'hA2, 4'hF, 1'b0, 1'b1, 10'd4);
    beat(32'hA3, 4'hF, 1'b1, 1'b1, 10'd5);
    finish_burst();

    // WRAP with illegal length 3 beats: base 4, word 6 stays 6
    aw(4'h6, 32'h18, 8'd2, BurstWrap, RespSlverr, 1'b1);
    beat(32'hB0, 4'hF, 1'b0, 1'b1, 10'd6);
    beat(32'hB1, 4'hF, 1'b0, 1'b1, 10'd6);
    beat(32'hB2, 4'hF, 1'b1, 1'b1, 10'd6);
    finish_burst();

    // FIXED 3 beats to word 8
    aw(4'h7, 32'h20, 8'd2, BurstFixed, RespOkay, 1'b1);
    beat(32'hC0, 4'h1, 1'b0, 1'b1, 10'd8);
    beat(32'hC1, 4'h2, 1'b0, 1'b1, 10'd8);
    beat(32'hC2, 4'hF, 1'b1, 1'b1, 10'd8);
    finish_burst();

    // Early wlast on beat 2: burst still runs 4 beats
    aw(4'h9, 32'h40, 8'd3, BurstIncr, RespSlverr, 1'b1);
    beat(32'hD0, 4'hF, 1'b0, 1'b1, 10'd16);
    beat(32'hD1, 4'hF, 1'b1, 1'b1, 10'd17);
    beat(32'hD2, 4'hF, 1'b0, 1'b1, 10'd18);
    beat(32'hD3, 4'hF, 1'b0, 1'b1, 10'd19);
    finish_burst();

    // Reserved burst type: written as INCR, answered SLVERR
    aw(4'hA, 32'h0, 8'd0, 2'd3, RespSlverr, 1'b1);
    beat(32'hE0, 4'hF, 1'b1, 1'b1, 10'd0);
    finish_burst();

    // Burst runs off the end of memory, with B back-pressure
    bready = 1'b0;
    aw(4'hB, 32'hFFC, 8'd1, BurstIncr, RespDecerr, 1'b1);
    beat(32'hF0, 4'hF, 1'b0, 1'b1, 10'd1023);
    beat(32'hF1, 4'hF, 1'b1, 1'b0, 10'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      check("bvalid_held", bvalid, 1'b1);
      check("bresp_held", bresp, 2'd3);
      check("bid_held", bid, 4'hB);
      check("awready_in_resp", awready, 1'b0);
    end
    @(posedge aclk);
    #1 bready = 1'b1;
    @(posedge aclk);
    #1;

    // Reset in the middle of an 8-beat burst: abandoned, no B
    aw(4'hC, 32'h80, 8'd7, BurstIncr, RespOkay, 1'b0);
    beat(32'h11, 4'hF, 1'b0, 1'b1, 10'd32);
    beat(32'h22, 4'hF, 1'b0, 1'b1, 10'd33);
    wdata = 32'h33; wstrb = 4'hF; wvalid = 1'b1;
    #2 aresetn = 1'b0;
    #1;
    check("wready_async_rst", wready, 1'b0);
    check("mem_we_async_rst", mem_we, 1'b0);
    check("bvalid_async_rst", bvalid, 1'b0);
    wvalid = 1'b0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("awready_in_rst", awready, 1'b0);
    @(posedge aclk);
    #1 aresetn = 1'b1;
    @(posedge aclk);
    @(posedge aclk);
    #1;
    check("awready_after_rst2", awready, 1'b1);
    check("bvalid_after_rst2", bvalid, 1'b0);

    // Recovery burst after the abandoned one
    aw(4'hD, 32'h8, 8'd0, BurstIncr, RespOkay, 1'b1);
    beat(32'h55, 4'h5, 1'b1, 1'b1, 10'd2);
    finish_burst();

    repeat (4) @(posedge aclk);
    check("writes_pending", exp_wr.size(), 0);
    check("b_pending", exp_b.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
